// File: rtl/fir_pkg.sv
// Shared constants, saturation limits and state encoding for the FIR tap stages.
package fir_pkg;

    localparam int N_DEF    = 8;
    localparam int FRAC_DEF = 7;

    // Largest value representable in an n-bit signed word.
    function automatic longint sat_max(input int n);
        return (longint'(1) <<< (n - 1)) - longint'(1);
    endfunction

    // Smallest value representable in an n-bit signed word.
    function automatic longint sat_min(input int n);
        return -(longint'(1) <<< (n - 1));
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fir_sat_mult.sv
// Signed fixed-point multiply: full-width product, arithmetic right shift by
// FRAC (rounds toward -inf), then clamp into the N-bit signed range.
module fir_sat_mult
    import fir_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] y
);

    localparam logic signed [2*N-1:0] MAX_W = (2*N)'(sat_max(N));
    localparam logic signed [2*N-1:0] MIN_W = (2*N)'(sat_min(N));
    localparam logic signed [N-1:0]   MAX_N = N'(sat_max(N));
    localparam logic signed [N-1:0]   MIN_N = N'(sat_min(N));

    logic signed [2*N-1:0] full;
    logic signed [2*N-1:0] shifted;

    // Multiply, scale back to the sample format and clamp on overflow.
    always_comb begin
        full    = a * b;
        shifted = full >>> FRAC;
        if (shifted > MAX_W) begin
            y = MAX_N;
        end else if (shifted < MIN_W) begin
            y = MIN_N;
        end else begin
            y = shifted[N-1:0];
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR tap stage: stores samples in a circular delay line and
// streams one saturated product per tap, one per clock, framed by first/last.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a sample; in_ready high, coefficient writes allowed
// RUN   | emitting tap k products, k = 0..TAPS-1; input and writes blocked
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int TAPS = 4,
    parameter int FRAC = FRAC_DEF,
    parameter int AW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                coef_we,
    input  logic [AW-1:0]       coef_addr,
    input  logic signed [N-1:0] coef_data,
    output logic signed [N-1:0] prod,
    output logic                prod_valid,
    output logic                prod_first,
    output logic                prod_last,
    output logic                busy
);

    localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
    // TAPS reduced modulo 2^AW; for power-of-two TAPS this is 0 and the
    // natural AW-bit wrap already performs the modulo.
    localparam logic [AW-1:0] TAPS_A = AW'(TAPS);
    localparam bit            FULL_ADDR_RANGE = (TAPS == (1 << AW));

    state_t state, state_nxt;

    logic signed [N-1:0] delay_q [TAPS];
    logic signed [N-1:0] coef_q  [TAPS];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       base;
    logic [AW-1:0]       k;
    logic [AW-1:0]       rd_idx;
    logic                accept;
    logic                addr_ok;
    logic signed [N-1:0] mult_y;

    // Read index walks backwards in time from the newest sample, wrapping mod TAPS.
    always_comb begin
        if (base >= k) begin
            rd_idx = base - k;
        end else begin
            rd_idx = base + TAPS_A - k;
        end
        addr_ok = FULL_ADDR_RANGE || (coef_addr < TAPS_A);
    end

    fir_sat_mult #(
        .N    (N),
        .FRAC (FRAC)
    ) u_mult (
        .a (delay_q[rd_idx]),
        .b (coef_q[k]),
        .y (mult_y)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (k == LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Delay line and coefficient storage; a write on the accepting edge
    // lands before the first product of that sample is computed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            if (accept) begin
                delay_q[wr_ptr] <= in_data;
            end
            if (coef_we && !busy && addr_ok) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

    // Write pointer, newest-sample base and tap counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            base   <= '0;
            k      <= '0;
        end else if (accept) begin
            base   <= wr_ptr;
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            k      <= '0;
        end else if (state == RUN) begin
            k <= k + 1'b1;
        end
    end

    // Product output register; prod holds its value between bursts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            prod_first <= 1'b0;
            prod_last  <= 1'b0;
        end else if (state == RUN) begin
            prod       <= mult_y;
            prod_valid <= 1'b1;
            prod_first <= (k == '0);
            prod_last  <= (k == LAST);
        end else begin
            prod_valid <= 1'b0;
            prod_first <= 1'b0;
            prod_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer (N=8, TAPS=4, FRAC=7).
module tb_fir_tap_sequencer;

    localparam int TAPS = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic signed [7:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              coef_we = 1'b0;
    logic [1:0]        coef_addr = '0;
    logic signed [7:0] coef_data = '0;
    logic signed [7:0] prod;
    logic              prod_valid, prod_first, prod_last, busy;

    fir_tap_sequencer #(.N(8), .TAPS(TAPS), .FRAC(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_first (prod_first),
        .prod_last  (prod_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model: newest-first sample history and coefficient array.
    int hist[$];
    int mcoef[TAPS];
    int exp_p[TAPS];
    int got[TAPS];

    typedef struct {
        int c0;
        int x;
        int exp0;
    } vec_t;
    vec_t vt[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_prod(input int x, input int c);
        int s;
        s = (x * c) >>> 7;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < TAPS; i++) mcoef[i] = 0;
    endtask

    task automatic model_accept(input int x);
        hist.push_front(x);
        if (hist.size() > TAPS) void'(hist.pop_back());
        for (int i = 0; i < TAPS; i++)
            exp_p[i] = ref_prod((i < hist.size()) ? hist[i] : 0, mcoef[i]);
    endtask

    task automatic write_coef(input int a, input int d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 2'(a); coef_data = 8'(d);
        @(posedge clk);
        #1 coef_we = 1'b0;
        if (a < TAPS) mcoef[a] = d;
    endtask

    task automatic send_sample(input int x, input bit busy_wr);
        int to;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'(x); to = 0;
        while (!in_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (!in_ready) begin
            check("accept_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(x);
        #1 in_valid = 1'b0;
        if (busy_wr) begin
            coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd0;
        end
        for (int k = 0; k < TAPS; k++) begin
            @(posedge clk);
            #1;
            got[k] = int'(prod);
            check("prod", int'(prod), exp_p[k]);
            check("prod_valid", int'(prod_valid), 1);
            check("prod_first", int'(prod_first), (k == 0) ? 1 : 0);
            check("prod_last", int'(prod_last), (k == TAPS - 1) ? 1 : 0);
            check("busy_run", int'(busy), (k < TAPS - 1) ? 1 : 0);
            check("in_ready_run", int'(in_ready), (k < TAPS - 1) ? 0 : 1);
            if (busy_wr && k == TAPS - 2) coef_we = 1'b0;
        end
    endtask

    initial begin
        int acc_cyc[3];
        int low_cnt[3];
        int nacc;
        int held;

        vt[0] = '{-128, -128,  127};
        vt[1] = '{-128,  127, -127};
        vt[2] = '{ 127, -128, -127};
        vt[3] = '{  64,   64,   32};
        vt[4] = '{  64,   -1,   -1};
        vt[5] = '{   1,    1,    0};
        vt[6] = '{ 127,  127,  126};
        vt[7] = '{  -1,    1,   -1};

        // Reset, then asynchronous release between edges.
        model_reset();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_prod", int'(prod), 0);
        check("rst_prod_valid", int'(prod_valid), 0);
        check("rst_first", int'(prod_first), 0);
        check("rst_last", int'(prod_last), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("idle_no_valid", int'(prod_valid), 0);
        end

        // Impulse through 0.5 coefficients.
        for (int i = 0; i < TAPS; i++) write_coef(i, 64);
        send_sample(64, 1'b0);
        check("impulse_k0", got[0], 32);
        for (int j = 1; j < TAPS; j++) begin
            send_sample(0, 1'b0);
            check("impulse_diag", got[j], 32);
        end
        @(posedge clk);
        #1 check("valid_drops", int'(prod_valid), 0);
        check("prod_holds", int'(prod), 32);

        // Wrap-around with -1.0 coefficients.
        for (int i = 0; i < TAPS; i++) write_coef(i, -128);
        for (int s = 1; s <= 5; s++) send_sample(s, 1'b0);
        for (int k = 0; k < TAPS; k++) check("wrap", got[k], -(5 - k));

        // Table of c0 / sample saturation and rounding cases.
        foreach (vt[i]) begin
            write_coef(0, vt[i].c0);
            send_sample(vt[i].x, 1'b0);
            check("tbl_k0", got[0], vt[i].exp0);
        end

        // Handshake: in_valid held high, acceptances every TAPS+1 cycles.
        write_coef(0, 64); write_coef(1, 32); write_coef(2, -16); write_coef(3, 100);
        nacc = 0;
        for (int i = 0; i < 3; i++) low_cnt[i] = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'sd10;
        for (int i = 0; i < 30; i++) begin
            if (in_ready) begin
                if (nacc == 3) begin
                    in_valid = 1'b0;
                    break;
                end
                acc_cyc[nacc] = cyc;
                nacc++;
                model_accept(10);
            end else if (nacc > 0) begin
                low_cnt[nacc-1]++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("hs_count", nacc, 3);
        if (nacc == 3) begin
            check("hs_gap1", acc_cyc[1] - acc_cyc[0], TAPS + 1);
            check("hs_gap2", acc_cyc[2] - acc_cyc[1], TAPS + 1);
            for (int i = 0; i < 3; i++) check("hs_ready_low", low_cnt[i], TAPS);
        end

        // Coefficient write during RUN is ignored.
        send_sample(100, 1'b1);
        check("busy_wr_k0", got[0], 50);
        send_sample(-100, 1'b0);
        check("c0_kept", got[0], -50);

        // Random coefficients and samples against the model.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0)
                write_coef($urandom_range(0, TAPS - 1), int'($urandom_range(0, 255)) - 128);
            send_sample(int'($urandom_range(0, 255)) - 128, 1'b0);
        end

        // Asynchronous reset in the middle of a burst.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'sd77;
        held = 0;
        while (!in_ready && held < 20) begin
            @(negedge clk);
            held++;
        end
        check("abort_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("abort_mid_valid", int'(prod_valid), 1);
        check("abort_mid_busy", int'(busy), 1);
        #1 rst = 1'b0;
        #1;
        check("abort_prod_valid", int'(prod_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_prod", int'(prod), 0);
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        send_sample(50, 1'b0);
        for (int k = 0; k < TAPS; k++) check("post_rst_zero", got[k], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
